inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/if_pkg.sv | 18 +
 rtl/inst_fifo.sv | 55 +++++
 rtl/inst_fetch.sv | 135 +++++++++++++
 tb/tb_inst_fetch.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction fetch unit: NOP default, FSM states, buffer entry.
package if_pkg;

  localparam logic [31:0] NOP_INST_DEF = 32'h00000013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        misalign;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous instruction buffer; flush empties it on the next edge.
module inst_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked by empty downstream.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding imem request, responses buffered in inst_fifo.
// Optional IF_MISALIGN_CHECK_EN turns misaligned PCs into flagged NOP entries.
//
// state  | meaning
// IDLE   | one cycle after reset before fetching starts
// REQ    | issue request for pc when buffer has room and no flush
// WAIT   | request granted, waiting for imem_rvalid (drop marks a flushed fetch)
module inst_fetch
  import if_pkg::*;
#(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
`ifdef IF_MISALIGN_CHECK_EN
  output logic        inst_misalign,
`endif
  input  logic        inst_ready
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [31:0]  req_pc;
  logic         req_pc_load;
  logic         drop;
  logic         drop_nxt;
  logic         push;
  fetch_entry_t push_data;
  fetch_entry_t head;
  logic         fifo_empty;
  logic         fifo_full;
  logic         misalign_pc;

`ifdef IF_MISALIGN_CHECK_EN
  assign misalign_pc = (pc[1:0] != 2'b00);
`else
  assign misalign_pc = 1'b0;
`endif

  assign imem_addr = {pc[31:2], 2'b00};

  always_comb begin
    state_nxt          = state;
    drop_nxt           = drop;
    imem_req           = 1'b0;
    pc_ready           = 1'b0;
    req_pc_load        = 1'b0;
    push               = 1'b0;
    push_data.pc       = req_pc;
    push_data.inst     = imem_rdata;
    push_data.misalign = 1'b0;
    unique case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (!fifo_full && !flush) begin
          if (misalign_pc) begin
            pc_ready           = 1'b1;
            push               = 1'b1;
            push_data.pc       = pc;
            push_data.inst     = NOP_INST;
            push_data.misalign = 1'b1;
          end else begin
            imem_req = 1'b1;
            if (imem_gnt) begin
              pc_ready    = 1'b1;
              req_pc_load = 1'b1;
              state_nxt   = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        // A response arriving with flush or after one is stale and is dropped.
        if (imem_rvalid) begin
          push      = !flush && !drop;
          drop_nxt  = 1'b0;
          state_nxt = S_REQ;
        end else if (flush) begin
          drop_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      drop   <= 1'b0;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      if (req_pc_load) req_pc <= pc;
    end
  end

  inst_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (push),
    .push_data(push_data),
    .pop      (inst_ready),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign inst_valid = !fifo_empty;
  assign inst       = fifo_empty ? NOP_INST : head.inst;
  assign inst_pc    = fifo_empty ? 32'h0 : head.pc;

`ifdef IF_MISALIGN_CHECK_EN
  assign inst_misalign = !fifo_empty && head.misalign;
`else
  logic unused_misalign;
  assign unused_misalign = head.misalign;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed vector bench for inst_fetch; the memory is played cycle by cycle from the table.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef IF_MISALIGN_CHECK_EN
  logic        inst_misalign;
`endif

  inst_fetch #(.FIFO_DEPTH(2), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .pc_ready   (pc_ready),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
`ifdef IF_MISALIGN_CHECK_EN
    .inst_misalign(inst_misalign),
`endif
    .inst_ready (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [31:0] pc;
    logic        flush;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic        e_prdy;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic add(input logic r, input logic [31:0] p, input logic f, input logic g,
                     input logic rv, input logic [31:0] rd, input logic rdy,
                     input logic er, input logic ep, input logic ev,
                     input logic [31:0] ei, input logic [31:0] epc);
    vec_t v;
    v.rst_n = r;  v.pc = p;   v.flush = f;  v.gnt = g;   v.rvalid = rv;
    v.rdata = rd; v.ready = rdy;
    v.e_req = er; v.e_prdy = ep; v.e_valid = ev; v.e_inst = ei; v.e_pc = epc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] p, input logic f, input logic g,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    @(negedge clk);
    rst_n = r; pc = p; flush = f; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    inst_ready = rdy;
    #1;
    nvec++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; pc = '0; flush = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    repeat (3) @(posedge clk);

    //  rst pc     fl gnt rv rdata          rdy   req prdy val inst           pc
    add(0, 32'd0,  0, 1, 0, 32'h0,         1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd0,  0, 1, 0, 32'h0,         1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd0,  0, 1, 0, 32'h0,         1,    1, 1, 0, NOP,           32'd0);
    add(1, 32'd4,  0, 1, 1, 32'hA000_0000, 1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd4,  0, 1, 0, 32'h0,         1,    1, 1, 1, 32'hA000_0000, 32'd0);
    add(1, 32'd8,  0, 1, 1, 32'hA000_0001, 1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd8,  0, 1, 0, 32'h0,         1,    1, 1, 1, 32'hA000_0001, 32'd4);
    add(1, 32'd12, 0, 1, 1, 32'hA000_0002, 1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd12, 0, 0, 0, 32'h0,         1,    1, 0, 1, 32'hA000_0002, 32'd8);
    // backpressure: fill two entries, requests held off, then drain in order
    add(1, 32'd12, 0, 1, 0, 32'h0,         0,    1, 1, 0, NOP,           32'd0);
    add(1, 32'd16, 0, 1, 1, 32'hB000_0000, 0,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd16, 0, 1, 0, 32'h0,         0,    1, 1, 1, 32'hB000_0000, 32'd12);
    add(1, 32'd20, 0, 1, 1, 32'hB000_0001, 0,    0, 0, 1, 32'hB000_0000, 32'd12);
    add(1, 32'd20, 0, 1, 0, 32'h0,         0,    0, 0, 1, 32'hB000_0000, 32'd12);
    add(1, 32'd20, 0, 1, 0, 32'h0,         0,    0, 0, 1, 32'hB000_0000, 32'd12);
    add(1, 32'd20, 0, 1, 0, 32'h0,         1,    0, 0, 1, 32'hB000_0000, 32'd12);
    add(1, 32'd20, 0, 1, 0, 32'h0,         1,    1, 1, 1, 32'hB000_0001, 32'd16);
    add(1, 32'd24, 0, 1, 1, 32'hB000_0002, 1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd24, 0, 0, 0, 32'h0,         1,    1, 0, 1, 32'hB000_0002, 32'd20);
    // flush while waiting, response three cycles after grant is dropped
    add(1, 32'd24, 0, 1, 0, 32'h0,         1,    1, 1, 0, NOP,           32'd0);
    add(1, 32'd24, 1, 1, 0, 32'h0,         1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd40, 0, 1, 0, 32'h0,         1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd40, 0, 1, 1, 32'hDEAD_BEEF, 1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd40, 0, 1, 0, 32'h0,         1,    1, 1, 0, NOP,           32'd0);
    add(1, 32'd44, 0, 1, 1, 32'hC000_0000, 1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd44, 0, 0, 0, 32'h0,         1,    1, 0, 1, 32'hC000_0000, 32'd40);
    // flush coincident with rvalid while one entry is buffered
    add(1, 32'd44, 0, 1, 0, 32'h0,         0,    1, 1, 0, NOP,           32'd0);
    add(1, 32'd48, 0, 1, 1, 32'hD000_0000, 0,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd48, 0, 1, 0, 32'h0,         0,    1, 1, 1, 32'hD000_0000, 32'd44);
    add(1, 32'd48, 1, 1, 1, 32'hD000_0001, 0,    0, 0, 1, 32'hD000_0000, 32'd44);
    add(1, 32'd64, 0, 0, 0, 32'h0,         0,    1, 0, 0, NOP,           32'd0);
    // flush in REQ suppresses the request that cycle
    add(1, 32'd64, 1, 1, 0, 32'h0,         1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd64, 0, 1, 0, 32'h0,         1,    1, 1, 0, NOP,           32'd0);
    add(1, 32'd68, 0, 1, 1, 32'hE000_0000, 1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd68, 0, 0, 0, 32'h0,         1,    1, 0, 1, 32'hE000_0000, 32'd64);
    // reset while waiting; the late response is ignored
    add(1, 32'd68, 0, 1, 0, 32'h0,         1,    1, 1, 0, NOP,           32'd0);
    add(0, 32'd68, 0, 1, 0, 32'h0,         1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd68, 0, 1, 1, 32'hF000_0000, 1,    0, 0, 0, NOP,           32'd0);
    add(1, 32'd68, 0, 0, 0, 32'h0,         1,    1, 0, 0, NOP,           32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].pc, vecs[i].flush, vecs[i].gnt,
            vecs[i].rvalid, vecs[i].rdata, vecs[i].ready);
      chk("imem_req",   i, 32'(imem_req),   32'(vecs[i].e_req));
      chk("pc_ready",   i, 32'(pc_ready),   32'(vecs[i].e_prdy));
      chk("inst_valid", i, 32'(inst_valid), 32'(vecs[i].e_valid));
      chk("inst",       i, inst,            vecs[i].e_inst);
      chk("inst_pc",    i, inst_pc,         vecs[i].e_pc);
      if (vecs[i].e_req) chk("imem_addr", i, imem_addr, {vecs[i].pc[31:2], 2'b00});
`ifdef IF_MISALIGN_CHECK_EN
      chk("inst_misalign", i, 32'(inst_misalign), 32'd0);
`endif
    end

    // FSM is now in REQ with an empty buffer; exercise a PC with low bits set.
`ifdef IF_MISALIGN_CHECK_EN
    drive(1, 32'h6, 0, 1, 0, 32'h0, 1);
    chk("mis_req",   100, 32'(imem_req),   32'd0);
    chk("mis_prdy",  100, 32'(pc_ready),   32'd1);
    chk("mis_valid", 100, 32'(inst_valid), 32'd0);
    drive(1, 32'h8, 0, 0, 0, 32'h0, 1);
    chk("mis_valid", 101, 32'(inst_valid),    32'd1);
    chk("mis_inst",  101, inst,               32'h00000013);
    chk("mis_pc",    101, inst_pc,            32'h6);
    chk("mis_flag",  101, 32'(inst_misalign), 32'd1);
    chk("mis_req",   101, 32'(imem_req),      32'd1);
    drive(1, 32'h8, 0, 0, 0, 32'h0, 1);
    chk("mis_valid", 102, 32'(inst_valid),    32'd0);
    chk("mis_flag",  102, 32'(inst_misalign), 32'd0);
`else
    drive(1, 32'h6, 0, 1, 0, 32'h0, 1);
    chk("mis_req",   100, 32'(imem_req),  32'd1);
    chk("mis_addr",  100, imem_addr,      32'h4);
    chk("mis_prdy",  100, 32'(pc_ready),  32'd1);
    drive(1, 32'h8, 0, 0, 1, 32'h1111_2222, 1);
    chk("mis_req",   101, 32'(imem_req),   32'd0);
    chk("mis_valid", 101, 32'(inst_valid), 32'd0);
    drive(1, 32'h8, 0, 0, 0, 32'h0, 1);
    chk("mis_valid", 102, 32'(inst_valid), 32'd1);
    chk("mis_inst",  102, inst,            32'h1111_2222);
    chk("mis_pc",    102, inst_pc,         32'h6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
